fetch_sequencer: RTL and testbench

//  Control FSM that drives the 2-bit state bus consumed by the program counter.

---
 rtl/fetch_sequencer.sv | 102 ++++++++++
 tb/tb_fetch_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Fetch/execute sequencing FSM that drives the program counter's 2-bit state bus.
// Each instruction runs FETCH (MEM_LATENCY cycles), EXEC (handshake), INCREMENT (1 cycle).
// Ports: clk/rst (sync, active-high), start, pc_in, mem_rdata in; state, instr_out,
//        instr_valid (with instr_ready in), busy, done out. EXEC holds indefinitely
//        while instr_ready is low.
module fetch_sequencer #(
  parameter int             MAX_COUNT     = 4,
  parameter int             ADDR_W        = 7,
  parameter int             INSTR_W       = 16,
  parameter int             MEM_LATENCY   = 2,
  parameter logic [1:0]     IDLE_FSM      = 2'd0,
  parameter logic [1:0]     RE_EN_FSM     = 2'd1,
  parameter logic [1:0]     INCREMENT_FSM = 2'd2,
  parameter logic [1:0]     EXEC_FSM      = 2'd3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [1:0]         state,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE = IDLE_FSM,
    S_FETCH = RE_EN_FSM,
    S_INCR = INCREMENT_FSM,
    S_EXEC = EXEC_FSM
  } state_t;

  state_t      cur;
  logic [3:0]  wait_cnt;
  logic [31:0] pc_ext;

  // PC comparisons are done on a 32-bit zero-extended copy so MAX_COUNT
  // can be compared without truncation for any ADDR_W.
  assign pc_ext = {{(32-ADDR_W){1'b0}}, pc_in};

  assign state = cur;
  assign busy  = (cur != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      cur         <= S_IDLE;
      instr_out   <= '0;
      instr_valid <= 1'b0;
      done        <= 1'b0;
      wait_cnt    <= 4'd0;
    end else begin
      case (cur)
        S_IDLE: begin
          if (start && !done) begin
            if (pc_ext < 32'(MAX_COUNT)) begin
              cur      <= S_FETCH;
              wait_cnt <= 4'd0;
            end else begin
              // Nothing left to run: flag completion without leaving IDLE.
              done <= 1'b1;
            end
          end
        end

        S_FETCH: begin
          wait_cnt <= wait_cnt + 4'd1;
          // Memory data is only trusted on the last fetch cycle.
          if (wait_cnt == 4'(MEM_LATENCY - 1)) begin
            instr_out   <= mem_rdata;
            instr_valid <= 1'b1;
            cur         <= S_EXEC;
          end
        end

        S_EXEC: begin
          if (instr_valid && instr_ready) begin
            instr_valid <= 1'b0;
            cur         <= S_INCR;
          end
        end

        S_INCR: begin
          // The program counter advances on this edge; pc_in still shows
          // the pre-increment value, hence the MAX_COUNT-1 compare.
          if (pc_ext == 32'(MAX_COUNT - 1)) begin
            cur  <= S_IDLE;
            done <= 1'b1;
          end else begin
            cur      <= S_FETCH;
            wait_cnt <= 4'd0;
          end
        end

        default: cur <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;
  localparam int MAXC = 4;
  localparam int LAT  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [6:0]  pc_in;
  logic [15:0] mem_rdata;
  logic [1:0]  state;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic        instr_ready;
  logic        busy;
  logic        done;

  int n_cmp  = 0;
  int n_fail = 0;

  fetch_sequencer #(.MAX_COUNT(MAXC), .ADDR_W(7), .INSTR_W(16), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .pc_in(pc_in), .mem_rdata(mem_rdata),
    .state(state), .instr_out(instr_out), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Bench-side program counter, optionally overridden.
  logic [6:0] pc_m = 7'd0;
  logic       force_en = 1'b0;
  logic [6:0] force_pc = 7'd0;
  assign pc_in = force_en ? force_pc : pc_m;

  // Behavioural reference: phase of the current instruction plus the edge
  // number at which its fetch began; the capture happens LAT edges later.
  int          m_phase = 0;     // 0 idle, 1 fetching, 2 increment, 3 handing off
  longint      edge_no = 0;
  longint      fetch_began = 0;
  logic [15:0] m_instr = 16'h0;
  bit          m_valid = 1'b0;
  bit          m_done  = 1'b0;

  always @(posedge clk) begin
    edge_no++;
    if (rst) begin
      pc_m    <= 7'd0;
      m_phase = 0;
      m_valid = 1'b0;
      m_instr = 16'h0;
      m_done  = 1'b0;
    end else begin
      if (m_phase == 2) pc_m <= pc_m + 7'd1;
      if (m_phase == 0) begin
        if (start && !m_done) begin
          if (int'(pc_in) < MAXC) begin
            m_phase = 1;
            fetch_began = edge_no;
          end else begin
            m_done = 1'b1;
          end
        end
      end else if (m_phase == 1) begin
        if (edge_no - fetch_began == longint'(LAT)) begin
          m_instr = mem_rdata;
          m_valid = 1'b1;
          m_phase = 3;
        end
      end else if (m_phase == 3) begin
        if (instr_ready) begin
          m_valid = 1'b0;
          m_phase = 2;
        end
      end else begin
        if (int'(pc_in) == MAXC - 1) begin
          m_phase = 0;
          m_done  = 1'b1;
        end else begin
          m_phase = 1;
          fetch_began = edge_no;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  bit check_en = 1'b0;
  always @(negedge clk) begin
    if (check_en) begin
      n_cmp += 5;
      if (int'(state) != m_phase) begin
        n_fail++; $display("FAIL model_state t=%0t got %0d want %0d", $time, state, m_phase);
      end
      if (instr_out !== m_instr) begin
        n_fail++; $display("FAIL model_instr t=%0t got %h want %h", $time, instr_out, m_instr);
      end
      if (instr_valid !== m_valid) begin
        n_fail++; $display("FAIL model_valid t=%0t got %b want %b", $time, instr_valid, m_valid);
      end
      if (busy !== (m_phase != 0)) begin
        n_fail++; $display("FAIL model_busy t=%0t got %b want %b", $time, busy, (m_phase != 0));
      end
      if (done !== m_done) begin
        n_fail++; $display("FAIL model_done t=%0t got %b want %b", $time, done, m_done);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  bit mem_track = 1'b0;  // drive mem_rdata = 16'h1000 + pc

  task automatic tick();
    @(negedge clk);
    if (mem_track) mem_rdata = 16'h1000 + 16'(pc_in);
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget);
    int k;
    k = 0;
    while (state !== s && k < budget) begin
      tick();
      k++;
    end
    n_cmp++;
    if (state !== s) begin
      n_fail++;
      $display("FAIL wait_state timeout got %0d want %0d", state, s);
    end
  endtask

  logic [15:0] handoffs[$];

  initial begin
    // 1. reset with random inputs
    rst = 1'b1;
    start = 1'(($urandom));
    instr_ready = 1'(($urandom));
    mem_rdata = 16'($urandom);
    tick();
    start = 1'(($urandom));
    instr_ready = 1'(($urandom));
    mem_rdata = 16'($urandom);
    tick();
    chk("rst_state", int'(state), 0);
    chk("rst_valid", int'(instr_valid), 0);
    chk("rst_instr", int'(instr_out), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    check_en = 1'b1;
    rst = 1'b0; start = 1'b0; instr_ready = 1'b1; mem_rdata = 16'hA5A5;

    // 2. one instruction: states 1,1,3,2 then 1
    start = 1'b1;
    tick(); chk("t2_s0", int'(state), 1); start = 1'b0;
    tick(); chk("t2_s1", int'(state), 1);
    tick(); chk("t2_s2", int'(state), 3);
    chk("t2_instr", int'(instr_out), 16'hA5A5);
    chk("t2_valid", int'(instr_valid), 1);
    tick(); chk("t2_s3", int'(state), 2);
    tick(); chk("t2_s4", int'(state), 1);

    // 3. backpressure in EXEC
    instr_ready = 1'b0; mem_rdata = 16'h1234;
    tick(); chk("t3_fetch", int'(state), 1);
    tick(); chk("t3_exec", int'(state), 3);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_hold_state", int'(state), 3);
      chk("t3_hold_instr", int'(instr_out), 16'h1234);
      chk("t3_hold_valid", int'(instr_valid), 1);
    end
    instr_ready = 1'b1;
    tick(); chk("t3_release", int'(state), 2);

    // 4. full program from pc=0
    rst = 1'b1; tick(); rst = 1'b0;
    instr_ready = 1'b1; mem_track = 1'b1; mem_rdata = 16'h1000 + 16'(pc_in);
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      if (instr_valid && instr_ready) handoffs.push_back(instr_out);
      tick();
    end
    chk("t4_count", handoffs.size(), 4);
    for (int i = 0; i < handoffs.size() && i < 4; i++)
      chk("t4_handoff", int'(handoffs[i]), 16'h1000 + i);
    chk("t4_state", int'(state), 0);
    chk("t4_done", int'(done), 1);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("t4_restart_ignored", int'(state), 0);
    end
    mem_track = 1'b0;

    // 5. start with pc already past the end
    rst = 1'b1; tick(); rst = 1'b0;
    force_en = 1'b1; force_pc = 7'd7;
    start = 1'b1; tick(); start = 1'b0;
    chk("t5_done", int'(done), 1);
    chk("t5_state", int'(state), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_idle", int'(state), 0);
      chk("t5_valid", int'(instr_valid), 0);
    end
    force_en = 1'b0;

    // 6. reset during stalled EXEC
    rst = 1'b1; tick(); rst = 1'b0;
    instr_ready = 1'b0; mem_rdata = 16'hBEEF;
    start = 1'b1; tick(); start = 1'b0;
    wait_state(2'd3, 20);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t6_state", int'(state), 0);
    chk("t6_valid", int'(instr_valid), 0);
    chk("t6_done", int'(done), 0);

    // 7. randomized traffic checked by the model
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 79) == 0);
      start       = ($urandom_range(0, 3) == 0);
      instr_ready = ($urandom_range(0, 2) != 0);
      mem_rdata   = 16'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
